// File: rtl/tone_square_gen_if.sv
// Bundles the tone request inputs and the generated tone/sample outputs of tone_square_gen.
// master = note decoder / sequencer side, slave = tone generator side.
interface tone_square_gen_if #(
    parameter int SAMPLE_W = 16
);
    logic [31:0]         div_in;
    logic                enable;
    logic [SAMPLE_W-1:0] volume;
    logic                tone_out;
    logic [SAMPLE_W-1:0] sample_out;
    logic                period_tick;
    logic [31:0]         active_div;

    modport master (
        output div_in, enable, volume,
        input  tone_out, sample_out, period_tick, active_div
    );

    modport slave (
        input  div_in, enable, volume,
        output tone_out, sample_out, period_tick, active_div
    );
endinterface

// File: rtl/tone_square_gen.sv
// Square-wave tone generator: plays div_in clock cycles per period, adopting new dividers only at period ends.
// Optional macro TONE_DEGLITCH_EN: div_in must be stable for STABLE_CYCLES cycles before it is accepted.
module tone_square_gen #(
    parameter int SAMPLE_W      = 16,
    parameter int STABLE_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    tone_square_gen_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [SAMPLE_W-1:0] VOL_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};

    state_t              state_reg, state_next;
    logic [31:0]         cnt_reg, cnt_next;
    logic [31:0]         active_div_reg, active_div_next;
    logic                tone_reg, tone_next;
    logic                tick_reg, tick_next;
    logic [SAMPLE_W-1:0] sample_reg, sample_next;
    logic [SAMPLE_W-1:0] vol_clamped;
    logic [31:0]         pending_div;
    logic                pending_valid;
    logic                load_ok;
    logic [31:0]         hi_len_pending;
    logic [31:0]         lo_len_active;

    if (STABLE_CYCLES < 2) begin : g_stable_chk
        $error("STABLE_CYCLES must be at least 2");
    end

`ifdef TONE_DEGLITCH_EN
    localparam int SC_W = $clog2(STABLE_CYCLES + 1);

    logic [31:0]   div_last_reg;
    logic [31:0]   pending_reg;
    logic [SC_W-1:0] stab_cnt_reg;

    // Any change of div_in restarts the stability count; the value is accepted once the count saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_last_reg <= '0;
            pending_reg  <= '0;
            stab_cnt_reg <= '0;
        end else if (bus.div_in != div_last_reg) begin
            div_last_reg <= bus.div_in;
            stab_cnt_reg <= '0;
        end else if (stab_cnt_reg == SC_W'(STABLE_CYCLES - 1)) begin
            pending_reg <= div_last_reg;
        end else begin
            stab_cnt_reg <= stab_cnt_reg + 1'b1;
        end
    end

    assign pending_div = pending_reg;
`else
    assign pending_div = bus.div_in;
`endif

    assign pending_valid  = |pending_div[31:1];
    assign load_ok        = bus.enable && pending_valid;
    assign hi_len_pending = pending_div >> 1;
    // Odd dividers put the extra cycle in LOW.
    assign lo_len_active  = active_div_reg - (active_div_reg >> 1);
    assign vol_clamped    = bus.volume[SAMPLE_W-1] ? VOL_MAX : bus.volume;

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        active_div_next = active_div_reg;
        tone_next       = tone_reg;
        tick_next       = 1'b0;

        case (state_reg)
            IDLE: begin
                tone_next       = 1'b0;
                active_div_next = '0;
                if (load_ok) begin
                    state_next      = HIGH;
                    active_div_next = pending_div;
                    cnt_next        = hi_len_pending - 32'd1;
                    tone_next       = 1'b1;
                    tick_next       = 1'b1;
                end
            end
            HIGH: begin
                if (cnt_reg == 32'd0) begin
                    state_next = LOW;
                    cnt_next   = lo_len_active - 32'd1;
                    tone_next  = 1'b0;
                end else begin
                    cnt_next = cnt_reg - 32'd1;
                end
            end
            LOW: begin
                if (cnt_reg == 32'd0) begin
                    if (load_ok) begin
                        state_next      = HIGH;
                        active_div_next = pending_div;
                        cnt_next        = hi_len_pending - 32'd1;
                        tone_next       = 1'b1;
                        tick_next       = 1'b1;
                    end else begin
                        state_next      = IDLE;
                        active_div_next = '0;
                        cnt_next        = '0;
                        tone_next       = 1'b0;
                    end
                end else begin
                    cnt_next = cnt_reg - 32'd1;
                end
            end
            default: begin
                state_next      = IDLE;
                active_div_next = '0;
                cnt_next        = '0;
                tone_next       = 1'b0;
            end
        endcase

        // Sample follows the next tone level so it stays aligned with tone_out.
        if (state_next == IDLE) begin
            sample_next = '0;
        end else if (tone_next) begin
            sample_next = vol_clamped;
        end else begin
            sample_next = '0 - vol_clamped;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            active_div_reg <= '0;
            tone_reg       <= 1'b0;
            tick_reg       <= 1'b0;
            sample_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            active_div_reg <= active_div_next;
            tone_reg       <= tone_next;
            tick_reg       <= tick_next;
            sample_reg     <= sample_next;
        end
    end

    assign bus.tone_out    = tone_reg;
    assign bus.sample_out  = sample_reg;
    assign bus.period_tick = tick_reg;
    assign bus.active_div  = active_div_reg;
endmodule
